// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the iterative restoring divider and its combinational step.
package restoring_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIVIDEND_W_DEF = 8;
  localparam int DIVISOR_W_DEF  = 4;
  localparam int CNT_W_DEF      = $clog2(DIVIDEND_W_DEF);

endpackage

// File: rtl/restoring_divider_div_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted
// partial remainder, restoring the shifted value when the subtraction borrows.
module div_step
  import restoring_divider_pkg::*;
#(
  parameter int DIVISOR_W = DIVISOR_W_DEF
) (
  input  logic [DIVISOR_W:0]   shifted,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] rem_next,
  output logic                 q_bit
);

  logic [DIVISOR_W-1:0] diff;

  // No borrow means the difference is below the divisor, so the low bits of a
  // narrow subtraction already hold the full result.
  assign q_bit    = (shifted >= {1'b0, divisor});
  assign diff     = shifted[DIVISOR_W-1:0] - divisor;
  assign rem_next = q_bit ? diff : shifted[DIVISOR_W-1:0];

endmodule

// File: rtl/restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake for sequencing by a controlling FSM.
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  state_t               state, next_state;
  logic [DIVIDEND_W-1:0] dvd;
  logic [DIVISOR_W-1:0]  dsr;
  logic [DIVISOR_W-1:0]  prem;
  logic [CNT_W-1:0]      cnt;
  logic [DIVISOR_W:0]    shifted;
  logic [DIVISOR_W-1:0]  rem_next;
  logic                  q_bit;

  // The dividend shift register doubles as the quotient register: quotient
  // bits enter at the LSB as dividend bits leave at the MSB.
  assign shifted = {prem, dvd[DIVIDEND_W-1]};

  div_step #(
    .DIVISOR_W(DIVISOR_W)
  ) u_step (
    .shifted (shifted),
    .divisor (dsr),
    .rem_next(rem_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == '0) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd         <= '0;
      dsr         <= '0;
      prem        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              dvd  <= dividend;
              dsr  <= divisor;
              prem <= '0;
              cnt  <= CNT_W'(DIVIDEND_W - 1);
            end else begin
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          dvd  <= {dvd[DIVIDEND_W-2:0], q_bit};
          prem <= rem_next;
          if (cnt == '0) begin
            quotient    <= {dvd[DIVIDEND_W-2:0], q_bit};
            remainder   <= rem_next;
            div_by_zero <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider against a plain-arithmetic reference.
module tb_restoring_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_cmp = 0;
  int n_mis = 0;

  restoring_divider #(
    .DIVIDEND_W(8),
    .DIVISOR_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance edge by edge until done, bounded; counts busy cycles on the way.
  task automatic wait_done(input int start_edges, output int edges, output int bcnt);
    edges = start_edges;
    bcnt  = 0;
    while (!done && edges < 20) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic check_result(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] eq;
    logic [3:0] er;
    logic       ez;
    if (b == 0) begin
      eq = 8'hFF; er = 4'd0; ez = 1'b1;
    end else begin
      eq = 8'(a / b); er = 4'(a % b); ez = 1'b0;
    end
    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    check("div_by_zero", 32'(div_by_zero), 32'(ez));
    if (b != 0) begin
      check("invariant", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      check("rem_lt_div", 32'(remainder < b), 32'd1);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [3:0] b);
    int edges, bcnt;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    wait_done(1, edges, bcnt);
    check("done_seen", 32'(done), 32'd1);
    check("latency", 32'(edges), (b == 0) ? 32'd1 : 32'd9);
    check("busy_cycles", 32'(bcnt), (b == 0) ? 32'd0 : 32'd8);
    check("busy_at_done", 32'(busy), 32'd0);
    check_result(a, b);
    @(posedge clk); #1;
    check("done_width", 32'(done), 32'd0);
  endtask

  initial begin
    int edges, bcnt, off;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quot", 32'(quotient), 32'd0);
    check("rst_rem", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op(8'd200, 4'd7);
    run_op(8'd255, 4'd15);
    run_op(8'd255, 4'd1);
    run_op(8'd5, 4'd9);
    run_op(8'd37, 4'd0);
    run_op(8'd10, 4'd3);

    // Outputs hold in IDLE and start is ignored while not idle.
    repeat (3) @(posedge clk);
    #1;
    check("hold_quot", 32'(quotient), 32'd3);
    check("hold_rem", 32'(remainder), 32'd1);
    check("idle_done", 32'(done), 32'd0);

    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 4'd3;
    @(posedge clk); #1;
    check("held_busy", 32'(busy), 32'd1);
    dividend = 8'd200; divisor = 4'd7;
    repeat (3) @(posedge clk);
    #1; start = 1'b0;
    @(posedge clk); #1; start = 1'b1; dividend = 8'd50; divisor = 4'd5;
    wait_done(5, edges, bcnt);
    check("held_done_seen", 32'(done), 32'd1);
    check("held_latency", 32'(edges), 32'd9);
    check_result(8'd100, 4'd3);
    @(posedge clk); #1;
    check("b2b_idle_busy", 32'(busy), 32'd0);
    check("b2b_idle_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("b2b_accept", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(1, edges, bcnt);
    check("b2b_done_seen", 32'(done), 32'd1);
    check("b2b_latency", 32'(edges), 32'd9);
    check_result(8'd50, 4'd5);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #2; rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_quot", 32'(quotient), 32'd0);
    check("arst_rem", 32'(remainder), 32'd0);
    check("arst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk); rst = 1'b0;
    run_op(8'd81, 4'd9);

    // Every operand pair, visited in a randomly offset odd-stride order.
    off = int'($urandom_range(0, 4095));
    for (int i = 0; i < 4096; i++) begin
      int idx;
      idx = (i * 2731 + off) % 4096;
      run_op(8'(idx >> 4), 4'(idx));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
